// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory
// Stream: 16-bit word count N (low byte first), then 4*N data bytes.
// Ports: clk/reset (sync, active high); load_req arms a load; in_data/in_valid/in_ready byte stream;
//        wr_en/wr_addr/wr_data imem write port; cpu_hold drives core reset; done one-cycle pulse; err sticky.
// Optional: define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the data.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS   = 64,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN0  = 3'd1;
  localparam logic [2:0] LEN1  = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] CSUM  = 3'd6;
  logic [2:0]  state;
  logic [15:0] count;
  logic [15:0] index;
  logic [1:0]  byte_cnt;
  logic [31:0] word;
  logic [7:0]  csum;
  logic        acc;
  assign in_ready = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
  assign acc = in_valid && in_ready;
  // Write-cycle outputs are registered on the 4th-byte handshake so they are
  // visible exactly during the single WRITE state cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_en    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wr_addr  <= BASE_ADDR;
      wr_data  <= 32'h0;
      cpu_hold <= HOLD_AT_RESET;
      count    <= 16'h0;
      index    <= 16'h0;
      byte_cnt <= 2'd0;
      word     <= 32'h0;
      csum     <= 8'h0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE, DONE: if (load_req) begin
          state    <= LEN0;
          cpu_hold <= 1'b1;
          err      <= 1'b0;
          index    <= 16'h0;
          byte_cnt <= 2'd0;
          csum     <= 8'h0;
        end
        LEN0: if (acc) begin
          count[7:0] <= in_data;
          state      <= LEN1;
        end
        LEN1: if (acc) begin
          count[15:8] <= in_data;
          if ({in_data, count[7:0]} != 16'h0) state <= DATA;
          else if (CSUM_EN) state <= CSUM;
          else begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
        DATA: if (acc) begin
          word[{byte_cnt, 3'b000} +: 8] <= in_data;
          byte_cnt <= byte_cnt + 2'd1;
          csum     <= csum ^ in_data;
          if (byte_cnt == 2'd3) begin
            state   <= WRITE;
            wr_en   <= 32'(index) < DEPTH_WORDS;
            err     <= err | (32'(index) >= DEPTH_WORDS);
            wr_addr <= BASE_ADDR + {14'h0, index, 2'b00};
            wr_data <= {in_data, word[23:0]};
            index   <= index + 16'd1;
            if (!CSUM_EN && index + 16'd1 == count) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end
          end
        end
        WRITE: state <= (index == count) ? (CSUM_EN ? CSUM : DONE) : DATA;
        CSUM: if (acc) begin
          state    <= DONE;
          done     <= 1'b1;
          cpu_hold <= in_data != csum;
          err      <= err | (in_data != csum);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (second instance with DEPTH_WORDS=2 for overflow)
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_req = 1'b0;
  logic [7:0]  in_data = 8'h0;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, cpu_hold, done, err;
  logic [31:0] wr_addr, wr_data;
  logic        in_ready2, wr_en2, cpu_hold2, done2, err2;
  logic [31:0] wr_addr2, wr_data2;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] wa[$], wd[$], wa2[$], wd2[$];
  int n_done = 0, n_done2 = 0;
  logic done_we, done_hold;
  logic [31:0] done_addr;
  logic [31:0] tbl [8] = '{32'h00000013, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D,
                           32'h00A00513, 32'hFFFFFFFF, 32'h80000001, 32'h0F1E2D3C};

  imem_loader dut (
    .clk(clk), .reset(reset), .load_req(load_req), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );
  imem_loader #(.DEPTH_WORDS(2)) dut2 (
    .clk(clk), .reset(reset), .load_req(load_req), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .cpu_hold(cpu_hold2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      chk("rdy_in_write", {31'h0, in_ready}, 32'h0);
    end
    if (wr_en2) begin
      wa2.push_back(wr_addr2);
      wd2.push_back(wr_data2);
    end
    if (done) begin
      n_done++;
      done_we = wr_en;
      done_hold = cpu_hold;
      done_addr = wr_addr;
    end
    if (done2) n_done2++;
  end

  task automatic clear_logs();
    wa.delete(); wd.delete(); wa2.delete(); wd2.delete();
    n_done = 0; n_done2 = 0; done_we = 1'b0; done_hold = 1'b1; done_addr = 32'hX;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    cycles(1);
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit hs;
    int budget;
    if (rnd) repeat ($urandom_range(0, 3)) cycles(1);
    in_data = b;
    in_valid = 1'b1;
    budget = 0;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      budget++;
      if (rnd && !hs && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        cycles(1);
        in_valid = 1'b1;
      end
    end while (!hs && budget < 50);
    if (!hs) chk("hs_timeout", 32'h1, 32'h0);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], rnd);
  endtask

  initial begin
    cycles(2);
    @(negedge clk);
    chk("rst_hold", {31'h0, cpu_hold}, 32'h1);
    chk("rst_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_wr_en", {31'h0, wr_en}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_addr", wr_addr, 32'h0);
    chk("rst_data", wr_data, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycles(2);
    clear_logs();
    start_load();
    chk("hold_loading", {31'h0, cpu_hold}, 32'h1);
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h00A00513, 0);
    send_word(32'h00500593, 0);
    cycles(3);
    chk("two_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("two_a0", wa[0], 32'h0);
      chk("two_d0", wd[0], 32'h00A00513);
      chk("two_a1", wa[1], 32'h4);
      chk("two_d1", wd[1], 32'h00500593);
    end
    chk("two_ndone", n_done, 1);
    chk("two_done_we", {31'h0, done_we}, 32'h1);
    chk("two_done_addr", done_addr, 32'h4);
    chk("two_done_hold", {31'h0, done_hold}, 32'h0);
    chk("two_hold_after", {31'h0, cpu_hold}, 32'h0);
    clear_logs();
    start_load();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    cycles(3);
    chk("zero_nwr", wa.size(), 0);
    chk("zero_ndone", n_done, 1);
    chk("zero_hold", {31'h0, cpu_hold}, 32'h0);
    chk("zero_err", {31'h0, err}, 32'h0);
    clear_logs();
    start_load();
    send_byte(8'h08, 1); send_byte(8'h00, 1);
    for (int i = 0; i < 8; i++) send_word(tbl[i], 1);
    cycles(3);
    chk("eight_nwr", wa.size(), 8);
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      chk($sformatf("eight_a%0d", i), wa[i], 32'(4 * i));
      chk($sformatf("eight_d%0d", i), wd[i], tbl[i]);
    end
    chk("eight_ndone", n_done, 1);
    chk("eight_hold", {31'h0, cpu_hold}, 32'h0);
    clear_logs();
    start_load();
    chk("ovf_err_cleared", {31'h0, err2}, 32'h0);
    send_byte(8'h03, 0); send_byte(8'h00, 0);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    send_word(32'h33333333, 0);
    cycles(3);
    chk("ovf_nwr2", wa2.size(), 2);
    if (wa2.size() == 2) begin
      chk("ovf_a1", wa2[1], 32'h4);
      chk("ovf_d1", wd2[1], 32'h22222222);
    end
    chk("ovf_err2", {31'h0, err2}, 32'h1);
    chk("ovf_ndone2", n_done2, 1);
    chk("ovf_nwr_full", wa.size(), 3);
    chk("ovf_err_full", {31'h0, err}, 32'h0);
    clear_logs();
    start_load();
    chk("abort_err_cleared", {31'h0, err2}, 32'h0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    reset = 1'b1;
    cycles(1);
    @(negedge clk);
    chk("abort_wr_en", {31'h0, wr_en}, 32'h0);
    chk("abort_hold", {31'h0, cpu_hold}, 32'h1);
    chk("abort_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycles(1);
    start_load();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(32'h12345678, 0);
    cycles(3);
    chk("abort_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("abort_a0", wa[0], 32'h0);
      chk("abort_d0", wd[0], 32'h12345678);
    end
    chk("abort_ndone", n_done, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
